cpu_run_controller: RTL and testbench

Run/step/breakpoint sequencer for the single-cycle MIPS core on the board. Instead of letting the core free-run on a divided clock, the core is clocked from the board clock and advanced only when this block asserts a one-cycle `CpuEn`. Advances come from a free-running RUN mode at a programmable rate, or from single STEP presses. RUN halts automatically when the core's PC matches a breakpoint address. Pushbuttons are synchronised and debounced internally.

---
 rtl/cpu_run_controller.sv | 162 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/breakpoint advance sequencer for the single-cycle MIPS core
// Core is clocked from Clk and advances only on the one-cycle CpuEn pulse issued here.

module cpu_run_debounce #(
  parameter int unsigned DebounceCycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DebounceCycles + 1);

  logic          sync1;
  logic          s;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // press is registered from the deb rising edge so the FSM acts 3+DebounceCycles edges after the first raw sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DebounceCycles - 1)) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module cpu_run_controller #(
  parameter int unsigned TickDiv        = 50000000,
  parameter int unsigned DebounceCycles = 1000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RunBtn,
  input  logic        StepBtn,
  input  logic        BreakEn,
  input  logic [31:0] BreakAddr,
  input  logic [31:0] PCValue,
  output logic        CpuEn,
  output logic [1:0]  State,
  output logic        Halted,
  output logic [31:0] InstrCount
);
  localparam int TW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [TW-1:0] TICK_TERM = TW'(TickDiv - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          skip_q, skip_d;
  logic          en_d;
  logic          run_ev;
  logic          step_ev;

  cpu_run_debounce #(.DebounceCycles(DebounceCycles)) u_run_deb (
    .clk   (Clk),
    .rst   (Rst),
    .btn   (RunBtn),
    .press (run_ev)
  );

  cpu_run_debounce #(.DebounceCycles(DebounceCycles)) u_step_deb (
    .clk   (Clk),
    .rst   (Rst),
    .btn   (StepBtn),
    .press (step_ev)
  );

  // Run press always takes priority over a simultaneous step press
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    skip_d  = skip_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_ev) begin
          state_d = RUN;
          tick_d  = '0;
          skip_d  = 1'b0;
        end else if (step_ev) begin
          state_d = STEP;
          en_d    = 1'b1;
        end
      end
      RUN: begin
        if (run_ev) begin
          state_d = IDLE;
        end else if (tick_q == TICK_TERM) begin
          tick_d = '0;
          if (BreakEn && (PCValue == BreakAddr) && !skip_q) begin
            state_d = BREAK;
          end else begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STEP: begin
        state_d = IDLE;
      end
      BREAK: begin
        // skip lets the instruction sitting at the breakpoint execute on resume
        if (run_ev) begin
          state_d = RUN;
          tick_d  = '0;
          skip_d  = 1'b1;
        end else if (step_ev) begin
          state_d = STEP;
          en_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      skip_q     <= 1'b0;
      CpuEn      <= 1'b0;
      Halted     <= 1'b0;
      InstrCount <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      skip_q     <= skip_d;
      CpuEn      <= en_d;
      Halted     <= (state_d == BREAK);
      InstrCount <= InstrCount + {31'd0, CpuEn};
    end
  end

  assign State = state_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller (TickDiv=8, DebounceCycles=4)

module tb_cpu_run_controller;
  localparam int TICK = 8;
  localparam int DEB  = 4;
  // edges from the first raw button sample to the FSM acting on it
  localparam int LAT  = 3 + DEB;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        RunBtn = 1'b0;
  logic        StepBtn = 1'b0;
  logic        BreakEn = 1'b0;
  logic [31:0] BreakAddr = 32'd0;
  logic [31:0] PCValue;
  logic        CpuEn;
  logic [1:0]  State;
  logic        Halted;
  logic [31:0] InstrCount;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc;

  typedef struct {
    int          cyc;
    logic [31:0] count;
    logic [31:0] pc;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t mon_e;

  cpu_run_controller #(.TickDiv(TICK), .DebounceCycles(DEB)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RunBtn     (RunBtn),
    .StepBtn    (StepBtn),
    .BreakEn    (BreakEn),
    .BreakAddr  (BreakAddr),
    .PCValue    (PCValue),
    .CpuEn      (CpuEn),
    .State      (State),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // core model: PC advances by 4 on every enabled cycle
  always @(posedge Clk) begin
    if (Rst) pc <= 32'd0;
    else if (CpuEn) pc <= pc + 32'd4;
  end
  assign PCValue = pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [31:0] count, input logic [31:0] p);
    pulse_t e;
    e.cyc   = c;
    e.count = count;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (CpuEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: CpuEn high after edge %0d, no pulse expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_edge", cyc, mon_e.cyc);
        check("pulse_count", InstrCount, mon_e.count);
        check("pulse_pc", PCValue, mon_e.pc);
      end
    end
  end

  initial begin
    int n;
    int m;
    int e;

    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    check("rst_state", State, 32'd0);
    check("rst_cpuen", CpuEn, 32'd0);
    check("rst_count", InstrCount, 32'd0);
    check("rst_halted", Halted, 32'd0);
    repeat (100) @(negedge Clk);
    check("idle_count", InstrCount, 32'd0);
    check("idle_state", State, 32'd0);

    // single step: held 10 cycles, one pulse LAT edges after first sample
    n = cyc;
    StepBtn = 1'b1;
    expect_pulse(n + 1 + LAT, 32'd0, 32'd0);
    repeat (10) @(negedge Clk);
    StepBtn = 1'b0;
    repeat (20) @(negedge Clk);
    check("step_state", State, 32'd0);
    check("step_count", InstrCount, 32'd1);
    check("step_drained", exp_q.size(), 32'd0);

    // 3-cycle glitch is rejected
    StepBtn = 1'b1;
    repeat (3) @(negedge Clk);
    StepBtn = 1'b0;
    repeat (20) @(negedge Clk);
    check("glitch_state", State, 32'd0);
    check("glitch_count", InstrCount, 32'd1);

    // free run without breakpoint, stopped by a second run press at n+42
    n = cyc;
    RunBtn = 1'b1;
    e = n + 1 + LAT;
    for (int k = 1; e + TICK * k < n + 42 + 1 + LAT; k++)
      expect_pulse(e + TICK * k, 32'(k), 32'(4 * k));
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    wait_until(n + 20);
    check("run_state", State, 32'd1);
    wait_until(n + 42);
    RunBtn = 1'b1;
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    wait_until(n + 42 + 1 + LAT);
    check("run_stop_state", State, 32'd0);
    repeat (20) @(negedge Clk);
    check("run_drained", exp_q.size(), 32'd0);
    check("run_count", InstrCount, 32'd6);

    // breakpoint at 0x0C
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    check("rst2_count", InstrCount, 32'd0);
    BreakEn = 1'b1;
    BreakAddr = 32'h0000000C;
    n = cyc;
    RunBtn = 1'b1;
    e = n + 1 + LAT;
    expect_pulse(e + 8,  32'd0, 32'h0);
    expect_pulse(e + 16, 32'd1, 32'h4);
    expect_pulse(e + 24, 32'd2, 32'h8);
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    wait_until(e + 32);
    check("brk_state", State, 32'd3);
    check("brk_halted", Halted, 32'd1);
    check("brk_count", InstrCount, 32'd3);
    repeat (10) @(negedge Clk);
    check("brk_hold_state", State, 32'd3);
    check("brk_hold_count", InstrCount, 32'd3);

    // resume: breakpointed instruction executes, then 0x10
    m = cyc;
    RunBtn = 1'b1;
    e = m + 1 + LAT;
    expect_pulse(e + 8,  32'd3, 32'hC);
    expect_pulse(e + 16, 32'd4, 32'h10);
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    wait_until(e + 1);
    check("resume_halted", Halted, 32'd0);
    check("resume_state", State, 32'd1);
    wait_until(m + 20);
    RunBtn = 1'b1;
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    wait_until(m + 20 + 1 + LAT);
    check("resume_stop_state", State, 32'd0);
    repeat (10) @(negedge Clk);
    check("brk_drained", exp_q.size(), 32'd0);
    check("brk_final_count", InstrCount, 32'd5);

    // run and step together: run wins; then reset during the first pulse
    n = cyc;
    RunBtn = 1'b1;
    StepBtn = 1'b1;
    e = n + 1 + LAT;
    expect_pulse(e + TICK, 32'd5, 32'h14);
    repeat (6) @(negedge Clk);
    RunBtn = 1'b0;
    StepBtn = 1'b0;
    wait_until(e);
    check("both_state", State, 32'd1);
    wait_until(e + TICK);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrun_rst_cpuen", CpuEn, 32'd0);
    check("midrun_rst_state", State, 32'd0);
    check("midrun_rst_count", InstrCount, 32'd0);
    Rst = 1'b0;
    repeat (30) @(negedge Clk);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_count", InstrCount, 32'd0);
    check("final_state", State, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
